// File: rtl/bus_mux_pkg.sv
// bus_mux_pkg: shared width default and per-gate delay for the bus mux.
`timescale 1ns/10ps
package bus_mux_pkg;
  localparam int  BUS_MUX_DEFAULT_WIDTH = 64;
  localparam real BUS_MUX_GATE_DELAY    = 0.05;
endpackage

// File: rtl/mux_2to1_bit.sv
// mux_2to1_bit: gate-level single-bit 2:1 cell; BUS_MUX_GATE_DELAY_EN gives each gate the package delay.
`timescale 1ns/10ps
module mux_2to1_bit
  import bus_mux_pkg::*;
(
  output logic out,
  input  logic in0,
  input  logic in1,
  input  logic sel
);
  logic sel_n, a0, a1;
`ifdef BUS_MUX_GATE_DELAY_EN
  not #(BUS_MUX_GATE_DELAY) u_inv (sel_n, sel);
  and #(BUS_MUX_GATE_DELAY) u_and0 (a0, in0, sel_n);
  and #(BUS_MUX_GATE_DELAY) u_and1 (a1, in1, sel);
  or  #(BUS_MUX_GATE_DELAY) u_or (out, a0, a1);
`else
  not u_inv (sel_n, sel);
  and u_and0 (a0, in0, sel_n);
  and u_and1 (a1, in1, sel);
  or  u_or (out, a0, a1);
`endif
endmodule

// File: rtl/bus_mux_2to1.sv
// bus_mux_2to1: WIDTH-bit 2:1 mux with combinational and registered outputs; BUS_MUX_GATE_DELAY_EN adds gate delays.
`timescale 1ns/10ps
module bus_mux_2to1
  import bus_mux_pkg::*;
#(
  parameter int WIDTH = BUS_MUX_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             sel,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_q
);
  logic [WIDTH-1:0] out_d;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    mux_2to1_bit u_cell (
      .out (out[i]),
      .in0 (in0[i]),
      .in1 (in1[i]),
      .sel (sel)
    );
  end
  assign out_d = reset_n ? out : '0;
  always_ff @(posedge clk) out_q <= out_d;
endmodule

// File: tb/tb_bus_mux_2to1.sv
// tb_bus_mux_2to1: randomized and directed checks of bus_mux_2to1 at WIDTH 16, 1 and 64.
`timescale 1ns/10ps
module tb_bus_mux_2to1;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] in0 = '0, in1 = '0, out, out_q;
  logic        sel = 1'b0;
  logic        b0 = 1'b0, b1 = 1'b0, bs = 1'b0, bo, boq;
  logic [63:0] w0 = '0, w1 = '0, wo, woq;
  logic        ws = 1'b0;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bus_mux_2to1 #(.WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n), .in0(in0), .in1(in1), .sel(sel), .out(out), .out_q(out_q)
  );
  bus_mux_2to1 #(.WIDTH(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .in0(b0), .in1(b1), .sel(bs), .out(bo), .out_q(boq)
  );
  bus_mux_2to1 #(.WIDTH(64)) dut64 (
    .clk(clk), .reset_n(reset_n), .in0(w0), .in1(w1), .sel(ws), .out(wo), .out_q(woq)
  );

  function automatic logic [15:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [15:0] r;
    for (int k = 0; k < 16; k++) r[k] = s ? b[k] : a[k];
    return r;
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; sel = 1'b1; in0 = 16'h0123; in1 = 16'hCDEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (out_q !== 16'h0000) begin errors++; $display("FAIL reset_out_q got=%h exp=0000", out_q); end
    checks++;
    if (out !== 16'hCDEF) begin errors++; $display("FAIL reset_out got=%h exp=cdef", out); end
    reset_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_q !== 16'hCDEF) begin errors++; $display("FAIL release_out_q got=%h exp=cdef", out_q); end
  endtask

  task automatic test_select();
    in0 = 16'h0123; in1 = 16'h4567;
    sel = 1'b0; #10;
    checks++;
    if (out !== 16'h0123) begin errors++; $display("FAIL sel0 got=%h exp=0123", out); end
    sel = 1'b1; #10;
    checks++;
    if (out !== 16'h4567) begin errors++; $display("FAIL sel1 got=%h exp=4567", out); end
  endtask

  task automatic test_latency();
    logic [15:0] prev;
    in0 = 16'h89AB; in1 = 16'hCDEF;
    @(negedge clk); sel = 1'b0;
    for (int c = 0; c < 8; c++) begin
      prev = model(in0, in1, sel);
      @(posedge clk); #1;
      sel = ~sel;
      #1;
      checks++;
      if (out_q !== prev) begin errors++; $display("FAIL latency cyc=%0d got=%h exp=%h", c, out_q, prev); end
      checks++;
      if (out !== model(in0, in1, sel)) begin errors++; $display("FAIL latency_out cyc=%0d got=%h", c, out); end
    end
  endtask

  task automatic test_bits();
    in0 = 16'hAAAA; in1 = 16'h5555; sel = 1'b0; #2;
    checks++;
    if (out !== 16'hAAAA) begin errors++; $display("FAIL bits_sel0 got=%h exp=aaaa", out); end
    sel = 1'b1; #2;
    checks++;
    if (out !== 16'h5555) begin errors++; $display("FAIL bits_sel1 got=%h exp=5555", out); end
  endtask

  task automatic test_equal();
    in0 = 16'hFFFF; in1 = 16'hFFFF;
    for (int k = 0; k < 4; k++) begin
      sel = k[0]; #2;
      checks++;
      if (out !== 16'hFFFF) begin errors++; $display("FAIL equal sel=%b got=%h exp=ffff", sel, out); end
    end
  endtask

  task automatic test_random();
    logic [15:0] nxt;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      in0 = 16'($urandom); in1 = 16'($urandom); sel = 1'($urandom);
      reset_n = ($urandom_range(0, 9) != 0);
      #1;
      checks++;
      if (out !== model(in0, in1, sel)) begin errors++; $display("FAIL rand_out cyc=%0d got=%h exp=%h", c, out, model(in0, in1, sel)); end
      nxt = reset_n ? model(in0, in1, sel) : 16'h0;
      @(posedge clk); #1;
      checks++;
      if (out_q !== nxt) begin errors++; $display("FAIL rand_out_q cyc=%0d got=%h exp=%h", c, out_q, nxt); end
    end
    reset_n = 1'b1;
  endtask

  task automatic test_width1();
    logic [2:0] v;
    logic       e;
    for (int k = 0; k < 8; k++) begin
      v = 3'(k);
      {bs, b1, b0} = v;
      e = v[2] ? v[1] : v[0];
      #2;
      checks++;
      if (bo !== e) begin errors++; $display("FAIL width1 combo=%0d got=%b exp=%b", k, bo, e); end
    end
  endtask

  task automatic test_width64();
    w0 = 64'h0; w1 = 64'hFFFF_FFFF_FFFF_FFFF; ws = 1'b1; #2;
    checks++;
    if (wo !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL width64_sel1 got=%h", wo); end
    ws = 1'b0; #2;
    checks++;
    if (wo !== 64'h0) begin errors++; $display("FAIL width64_sel0 got=%h", wo); end
    w0 = {$urandom, $urandom}; w1 = {$urandom, $urandom}; ws = 1'b1; #2;
    checks++;
    if (wo !== w1) begin errors++; $display("FAIL width64_rand got=%h exp=%h", wo, w1); end
  endtask

  initial begin
    test_reset();
    test_select();
    test_latency();
    test_bits();
    test_equal();
    test_random();
    test_width1();
    test_width64();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
